frame_bank_ctrl: RTL and testbench
==================================

# frame_bank_ctrl

Parametrised N-bank frame-buffer arbiter between a video writer (camera side) and a video reader (HDMI side) that share DDR frame banks. It synchronises both vertical-sync inputs and advances the write bank on each input frame start. It hands the reader the newest fully written frame, never letting reader and writer share a bank. It also reports dropped and repeated frames, and supports a freeze mode.

## Interface
- NUM_BANKS, 4, number of frame banks; legal range 3..16
- BANK_W, $clog2(NUM_BANKS), bank index width (derived)
- SYNC_STAGES, 2, synchroniser flops per vsync input; legal range 2..4
- CNT_W, 16, width of drop/repeat counters
- clk  in  1  single system clock (DDR user clock domain)
- rst  in  1  synchronous, active-high reset
- vin_vs  in  1  writer vsync, asynchronous; frame start = rising edge
- vout_vs  in  1  reader vsync, asynchronous; frame start = rising edge
- freeze  in  1  level; 1 = hold current write bank, publish no new frames
- wr_bank  out  BANK_W  bank the writer fills
- rd_bank  out  BANK_W  bank the reader displays
- wr_switch  out  1  one-cycle pulse when wr_bank is re-evaluated
- rd_switch  out  1  one-cycle pulse when rd_bank is re-evaluated
- drop_cnt  out  CNT_W  completed frames overwritten unread; saturating
- rep_cnt  out  CNT_W  reader frames that repeated the previous bank; saturating

## Operation
- Internal state:
  - done_bank (BANK_W): last completed write bank.
  - fresh (1 bit): done_bank has not yet been given to the reader.
- Reset values:
  - wr_bank=0
  - rd_bank=NUM_BANKS-1
  - done_bank=NUM_BANKS-1
  - fresh=0
  - drop_cnt=0
  - rep_cnt=0
  - wr_switch=0
  - rd_switch=0
- Edge events:
  - wr_ev is a rising edge of synchronised vin_vs.
  - rd_ev is a rising edge of synchronised vout_vs.
- Reader step on rd_ev:
  - If fresh, rd_nxt = done_bank.
  - Otherwise rd_nxt = rd_bank, and rep_cnt increments.
  - rd_switch pulses in both cases.
- Writer step on wr_ev with freeze=0:
  - done_bank <= wr_bank.
  - fresh <= 1.
  - If fresh was 1 and this cycle's reader step did not consume it, drop_cnt increments.
  - wr_bank <= cand, where cand = (wr_bank+1) mod NUM_BANKS.
  - If cand == rd_nxt, wr_bank <= (wr_bank+2) mod NUM_BANKS instead.
  - wr_switch pulses.
- Writer step on wr_ev with freeze=1:
  - wr_bank, done_bank and fresh are unchanged.
  - wr_switch still pulses.
  - The writer re-fills the same bank; no frame is published.
- Simultaneous wr_ev and rd_ev:
  - The reader step uses pre-update done_bank and fresh.
  - The writer step avoids rd_nxt.
  - fresh ends at 1, because the writer publishes a new frame.
- Invariants, checked by assertion:
  - wr_bank != rd_bank.
  - wr_bank != done_bank, whenever fresh=1.
- All modulo arithmetic is done in BANK_W+1 bits, then reduced; non-power-of-two NUM_BANKS must wrap correctly (e.g. 5 → 0).
- Counters saturate at all-ones and never wrap.
- freeze has no effect on the reader step.

## Timing
- Synchroniser:
  - SYNC_STAGES flops plus one history flop per input.
  - Event = last stage high AND history low.
- Latency: a vsync rising edge first sampled at clk edge k produces its event-driven output update at clk edge k+SYNC_STAGES. With SYNC_STAGES=2 that is the third edge counting k.
- Minimum vsync width: high or low for at least 2 clk cycles. Narrower pulses may be missed; that is legal and not an error.
- rst asserted mid-frame:
  - All state returns to reset values on the next edge.
  - Synchroniser and history flops clear to 0.
  - An input already high at reset release produces an event after the sync latency. This is the intended first-frame behaviour.

## Structure
- Package frame_bank_pkg:
  - clog2 helper.
  - Legal-range checks for NUM_BANKS and SYNC_STAGES, applied by elaboration-time assertions.
- Sub-module vs_edge_sync:
  - Parameter SYNC_STAGES.
  - Ports clk, rst, async_in, rise_pulse.
  - Instantiated twice.
- Top level holds the bank state, counters and invariant assertions.

## Test plan
All cases use NUM_BANKS=4 and SYNC_STAGES=2.
- Reset and first frame: after rst, raise vin_vs → wr_bank=0→1, done_bank=0, fresh=1, wr_switch pulse on the third edge; rd_bank stays 3.
- Normal flow: alternate single vin and vout edges → rd_bank follows the last completed bank; wr_bank sequence 1,2,3,0; drop_cnt=0, rep_cnt=0.
- Writer faster (3 vin edges per vout edge) → drop_cnt=2 per reader frame; on a collision wr_bank skips rd_bank (wr=1, rd=2 → next wr=3).
- Reader faster (2 vout edges per vin edge) → alternate rd_switch pulses repeat the same bank; rep_cnt increments by 1 per input frame.
- Simultaneous events: with wr=2, done=1, fresh=1, rd=0, fire vin and vout in the same cycle → rd=1, wr=3, done=2, fresh=1.
- Freeze and saturation:
  - freeze=1 with vin edges → wr_bank constant, wr_switch pulses, rd repeats.
  - Force rep_cnt to 16'hFFFF, then one more repeat → value stays 16'hFFFF.
  - NUM_BANKS=5 build: wr_bank wraps 4→0.

Source files
------------

// File: rtl/frame_bank_pkg.sv
// Shared helpers for the frame-bank arbiter: index-width computation and
// legal-range predicates checked when the design is elaborated.
package frame_bank_pkg;

  localparam int MIN_BANKS  = 3;
  localparam int MAX_BANKS  = 16;
  localparam int MIN_STAGES = 2;
  localparam int MAX_STAGES = 4;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((32'sd1 << r) < n) begin
        r = r + 1;
      end else begin
        r = r;
      end
    end
    return r;
  endfunction

  function automatic bit banks_legal(input int n);
    return (n >= MIN_BANKS) && (n <= MAX_BANKS);
  endfunction

  function automatic bit stages_legal(input int n);
    return (n >= MIN_STAGES) && (n <= MAX_STAGES);
  endfunction

endpackage

// File: rtl/vs_edge_sync.sv
// Brings an asynchronous vsync into the clock domain and emits a one-cycle
// pulse on its synchronised rising edge.
module vs_edge_sync
  import frame_bank_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic async_in,
  output logic rise_pulse
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   hist_q;

  if (!stages_legal(SYNC_STAGES)) begin : g_bad_stages
    $error("vs_edge_sync: SYNC_STAGES must be within 2..4");
  end

  // Shift chain plus one history flop for edge detection.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
      hist_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], async_in};
      hist_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign rise_pulse = sync_q[SYNC_STAGES-1] & ~hist_q;

endmodule

// File: rtl/frame_bank_ctrl.sv
// Frame-bank arbiter: gives the reader the newest completed frame while the
// writer rotates through the other banks, never sharing a bank with the reader.
module frame_bank_ctrl
  import frame_bank_pkg::*;
#(
  parameter int NUM_BANKS   = 4,
  parameter int BANK_W      = clog2(NUM_BANKS),
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              vin_vs,
  input  logic              vout_vs,
  input  logic              freeze,
  output logic [BANK_W-1:0] wr_bank,
  output logic [BANK_W-1:0] rd_bank,
  output logic              wr_switch,
  output logic              rd_switch,
  output logic [CNT_W-1:0]  drop_cnt,
  output logic [CNT_W-1:0]  rep_cnt
);

  localparam logic [BANK_W:0]   NB_EXT    = (BANK_W+1)'(NUM_BANKS);
  localparam logic [BANK_W-1:0] LAST_BANK = BANK_W'(NUM_BANKS - 1);
  localparam logic [BANK_W:0]   STEP1     = (BANK_W+1)'(1);
  localparam logic [BANK_W:0]   STEP2     = (BANK_W+1)'(2);

  if (!banks_legal(NUM_BANKS)) begin : g_bad_banks
    $error("frame_bank_ctrl: NUM_BANKS must be within 3..16");
  end

  // Sum is formed one bit wider so non-power-of-two bank counts wrap cleanly.
  function automatic logic [BANK_W-1:0] bank_add(input logic [BANK_W-1:0] b,
                                                 input logic [BANK_W:0]   step);
    logic [BANK_W:0] sum;
    sum = {1'b0, b} + step;
    return (sum >= NB_EXT) ? BANK_W'(sum - NB_EXT) : sum[BANK_W-1:0];
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (c == {CNT_W{1'b1}}) ? c : c + CNT_W'(1);
  endfunction

  logic              wr_ev_s, rd_ev_s;
  logic [BANK_W-1:0] cand_s;
  logic [BANK_W-1:0] wr_bank_q, wr_bank_d, rd_bank_q, rd_bank_d;
  logic [BANK_W-1:0] done_bank_q, done_bank_d;
  logic              fresh_q, fresh_d;
  logic [CNT_W-1:0]  drop_cnt_q, drop_cnt_d, rep_cnt_q, rep_cnt_d;
  logic              wr_switch_q, rd_switch_q;

  vs_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_vin_sync (
    .clk(clk), .rst(rst), .async_in(vin_vs), .rise_pulse(wr_ev_s)
  );

  vs_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_vout_sync (
    .clk(clk), .rst(rst), .async_in(vout_vs), .rise_pulse(rd_ev_s)
  );

  assign cand_s = bank_add(wr_bank_q, STEP1);

  // Reader step first; the writer then steers around the reader's next bank.
  always_comb begin
    rd_bank_d   = rd_bank_q;
    wr_bank_d   = wr_bank_q;
    done_bank_d = done_bank_q;
    fresh_d     = fresh_q;
    drop_cnt_d  = drop_cnt_q;
    rep_cnt_d   = rep_cnt_q;
    if (rd_ev_s) begin
      if (fresh_q) begin
        rd_bank_d = done_bank_q;
        fresh_d   = 1'b0;
      end else begin
        rep_cnt_d = sat_inc(rep_cnt_q);
      end
    end else begin
      rd_bank_d = rd_bank_q;
    end
    if (wr_ev_s && !freeze) begin
      done_bank_d = wr_bank_q;
      fresh_d     = 1'b1;
      wr_bank_d   = (cand_s == rd_bank_d) ? bank_add(wr_bank_q, STEP2) : cand_s;
      if (fresh_q && !rd_ev_s) begin
        drop_cnt_d = sat_inc(drop_cnt_q);
      end else begin
        drop_cnt_d = drop_cnt_q;
      end
    end else begin
      wr_bank_d = wr_bank_q;
    end
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_bank_q   <= '0;
      rd_bank_q   <= LAST_BANK;
      done_bank_q <= LAST_BANK;
      fresh_q     <= 1'b0;
      drop_cnt_q  <= '0;
      rep_cnt_q   <= '0;
      wr_switch_q <= 1'b0;
      rd_switch_q <= 1'b0;
    end else begin
      wr_bank_q   <= wr_bank_d;
      rd_bank_q   <= rd_bank_d;
      done_bank_q <= done_bank_d;
      fresh_q     <= fresh_d;
      drop_cnt_q  <= drop_cnt_d;
      rep_cnt_q   <= rep_cnt_d;
      wr_switch_q <= wr_ev_s;
      rd_switch_q <= rd_ev_s;
    end
  end

  assign wr_bank   = wr_bank_q;
  assign rd_bank   = rd_bank_q;
  assign wr_switch = wr_switch_q;
  assign rd_switch = rd_switch_q;
  assign drop_cnt  = drop_cnt_q;
  assign rep_cnt   = rep_cnt_q;

  a_wr_ne_rd: assert property (@(posedge clk) disable iff (rst) wr_bank_q != rd_bank_q);
  a_wr_ne_done: assert property (@(posedge clk) disable iff (rst)
                                 fresh_q |-> (wr_bank_q != done_bank_q));

endmodule

// File: tb/tb_frame_bank_ctrl.sv
// Directed bench for frame_bank_ctrl: a 4-bank/16-bit instance for the main
// scenarios and a 5-bank/2-bit instance for wrap and counter saturation.
module tb_frame_bank_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       vin = 1'b0, vout = 1'b0, freeze = 1'b0;
  logic       vin5 = 1'b0, vout5 = 1'b0;
  logic [1:0] wr_bank, rd_bank;
  logic       wr_switch, rd_switch;
  logic [15:0] drop_cnt, rep_cnt;
  logic [2:0] wr_bank5, rd_bank5;
  logic       wr_switch5, rd_switch5;
  logic [1:0] drop5, rep5;
  int         n_vec = 0;
  int         n_err = 0;

  always #5 clk = ~clk;

  frame_bank_ctrl #(.NUM_BANKS(4), .SYNC_STAGES(2), .CNT_W(16)) u_dut (
    .clk(clk), .rst(rst), .vin_vs(vin), .vout_vs(vout), .freeze(freeze),
    .wr_bank(wr_bank), .rd_bank(rd_bank), .wr_switch(wr_switch), .rd_switch(rd_switch),
    .drop_cnt(drop_cnt), .rep_cnt(rep_cnt)
  );

  frame_bank_ctrl #(.NUM_BANKS(5), .SYNC_STAGES(2), .CNT_W(2)) u_dut5 (
    .clk(clk), .rst(rst), .vin_vs(vin5), .vout_vs(vout5), .freeze(1'b0),
    .wr_bank(wr_bank5), .rd_bank(rd_bank5), .wr_switch(wr_switch5), .rd_switch(rd_switch5),
    .drop_cnt(drop5), .rep_cnt(rep5)
  );

  // Raise the selected vsyncs and return at the negedge after the update edge.
  task automatic fire(input bit vi, input bit vo, input bit fz, input bit sel);
    @(negedge clk);
    if (sel) begin
      vin5 = vi; vout5 = vo;
    end else begin
      vin = vi; vout = vo; freeze = fz;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic settle();
    vin = 1'b0; vout = 1'b0; vin5 = 1'b0; vout5 = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_vec++;
    if (wr_bank !== 2'd0 || rd_bank !== 2'd3 || wr_switch !== 1'b0 || rd_switch !== 1'b0 ||
        drop_cnt !== 16'd0 || rep_cnt !== 16'd0) begin
      n_err++;
      $display("FAIL reset4: wr=%0d rd=%0d wsw=%b rsw=%b drop=%0d rep=%0d, want 0 3 0 0 0 0",
               wr_bank, rd_bank, wr_switch, rd_switch, drop_cnt, rep_cnt);
    end
    n_vec++;
    if (wr_bank5 !== 3'd0 || rd_bank5 !== 3'd4 || drop5 !== 2'd0 || rep5 !== 2'd0) begin
      n_err++;
      $display("FAIL reset5: wr=%0d rd=%0d drop=%0d rep=%0d, want 0 4 0 0",
               wr_bank5, rd_bank5, drop5, rep5);
    end
    rst = 1'b0;
  endtask

  task automatic test_first_frame();
    @(negedge clk);
    vin = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_vec++;
    if (wr_switch !== 1'b0 || wr_bank !== 2'd0) begin
      n_err++;
      $display("FAIL first_early: wsw=%b wr=%0d, want 0 0", wr_switch, wr_bank);
    end
    @(posedge clk);
    @(negedge clk);
    n_vec++;
    if (wr_switch !== 1'b1 || wr_bank !== 2'd1 || rd_bank !== 2'd3 || rd_switch !== 1'b0) begin
      n_err++;
      $display("FAIL first_frame: wsw=%b wr=%0d rd=%0d rsw=%b, want 1 1 3 0",
               wr_switch, wr_bank, rd_bank, rd_switch);
    end
    settle();
    n_vec++;
    if (wr_switch !== 1'b0) begin
      n_err++;
      $display("FAIL first_pulse_end: wsw=%b, want 0", wr_switch);
    end
  endtask

  task automatic test_normal_flow();
    bit       vi_t [8] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    bit [1:0] ewr  [8] = '{2'd1, 2'd2, 2'd2, 2'd3, 2'd3, 2'd0, 2'd0, 2'd1};
    bit [1:0] erd  [8] = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd2, 2'd2, 2'd3, 2'd3};
    for (int i = 0; i < 8; i++) begin
      fire(vi_t[i], !vi_t[i], 1'b0, 1'b0);
      n_vec++;
      if (wr_bank !== ewr[i] || rd_bank !== erd[i] || wr_switch !== vi_t[i] ||
          rd_switch !== !vi_t[i] || drop_cnt !== 16'd0 || rep_cnt !== 16'd0) begin
        n_err++;
        $display("FAIL normal step %0d: wr=%0d rd=%0d wsw=%b rsw=%b drop=%0d rep=%0d, want wr=%0d rd=%0d drop=0 rep=0",
                 i, wr_bank, rd_bank, wr_switch, rd_switch, drop_cnt, rep_cnt, ewr[i], erd[i]);
      end
      settle();
    end
  endtask

  task automatic test_writer_faster();
    bit        vi_t [9] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    bit [1:0]  ewr  [9] = '{2'd1, 2'd2, 2'd3, 2'd1, 2'd1, 2'd2, 2'd0, 2'd1, 2'd1};
    bit [1:0]  erd  [9] = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd3, 2'd3, 2'd3, 2'd3, 2'd0};
    bit [15:0] edr  [9] = '{16'd0, 16'd0, 16'd1, 16'd2, 16'd2, 16'd2, 16'd3, 16'd4, 16'd4};
    for (int i = 0; i < 9; i++) begin
      fire(vi_t[i], !vi_t[i], 1'b0, 1'b0);
      n_vec++;
      if (wr_bank !== ewr[i] || rd_bank !== erd[i] || wr_switch !== vi_t[i] ||
          rd_switch !== !vi_t[i] || drop_cnt !== edr[i] || rep_cnt !== 16'd0) begin
        n_err++;
        $display("FAIL writer_fast step %0d: wr=%0d rd=%0d wsw=%b rsw=%b drop=%0d rep=%0d, want wr=%0d rd=%0d drop=%0d rep=0",
                 i, wr_bank, rd_bank, wr_switch, rd_switch, drop_cnt, rep_cnt, ewr[i], erd[i], edr[i]);
      end
      settle();
    end
  endtask

  task automatic test_reader_faster();
    bit        vi_t [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    bit [1:0]  ewr  [6] = '{2'd2, 2'd2, 2'd2, 2'd3, 2'd3, 2'd3};
    bit [1:0]  erd  [6] = '{2'd0, 2'd1, 2'd1, 2'd1, 2'd2, 2'd2};
    bit [15:0] erp  [6] = '{16'd0, 16'd0, 16'd1, 16'd1, 16'd1, 16'd2};
    for (int i = 0; i < 6; i++) begin
      fire(vi_t[i], !vi_t[i], 1'b0, 1'b0);
      n_vec++;
      if (wr_bank !== ewr[i] || rd_bank !== erd[i] || wr_switch !== vi_t[i] ||
          rd_switch !== !vi_t[i] || drop_cnt !== 16'd4 || rep_cnt !== erp[i]) begin
        n_err++;
        $display("FAIL reader_fast step %0d: wr=%0d rd=%0d wsw=%b rsw=%b drop=%0d rep=%0d, want wr=%0d rd=%0d drop=4 rep=%0d",
                 i, wr_bank, rd_bank, wr_switch, rd_switch, drop_cnt, rep_cnt, ewr[i], erd[i], erp[i]);
      end
      settle();
    end
  endtask

  task automatic test_simultaneous();
    bit       vi_t [7] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    bit       vo_t [7] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    bit [1:0] ewr  [7] = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd2, 2'd3, 2'd3};
    bit [1:0] erd  [7] = '{2'd2, 2'd3, 2'd3, 2'd0, 2'd0, 2'd1, 2'd2};
    for (int i = 0; i < 7; i++) begin
      fire(vi_t[i], vo_t[i], 1'b0, 1'b0);
      n_vec++;
      if (wr_bank !== ewr[i] || rd_bank !== erd[i] || wr_switch !== vi_t[i] ||
          rd_switch !== vo_t[i] || drop_cnt !== 16'd4 || rep_cnt !== 16'd2) begin
        n_err++;
        $display("FAIL simultaneous step %0d: wr=%0d rd=%0d wsw=%b rsw=%b drop=%0d rep=%0d, want wr=%0d rd=%0d drop=4 rep=2",
                 i, wr_bank, rd_bank, wr_switch, rd_switch, drop_cnt, rep_cnt, ewr[i], erd[i]);
      end
      settle();
    end
  endtask

  task automatic test_freeze();
    bit        fz_t [8] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    bit        vi_t [8] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    bit [1:0]  ewr  [8] = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd1, 2'd1};
    bit [1:0]  erd  [8] = '{2'd2, 2'd3, 2'd3, 2'd3, 2'd3, 2'd3, 2'd3, 2'd0};
    bit [15:0] erp  [8] = '{16'd2, 16'd2, 16'd2, 16'd3, 16'd3, 16'd4, 16'd4, 16'd4};
    for (int i = 0; i < 8; i++) begin
      fire(vi_t[i], !vi_t[i], fz_t[i], 1'b0);
      n_vec++;
      if (wr_bank !== ewr[i] || rd_bank !== erd[i] || wr_switch !== vi_t[i] ||
          rd_switch !== !vi_t[i] || drop_cnt !== 16'd4 || rep_cnt !== erp[i]) begin
        n_err++;
        $display("FAIL freeze step %0d: wr=%0d rd=%0d wsw=%b rsw=%b drop=%0d rep=%0d, want wr=%0d rd=%0d drop=4 rep=%0d",
                 i, wr_bank, rd_bank, wr_switch, rd_switch, drop_cnt, rep_cnt, ewr[i], erd[i], erp[i]);
      end
      settle();
    end
    freeze = 1'b0;
  endtask

  task automatic test_wrap_saturate();
    bit       vi_t [13] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    bit [2:0] ewr  [13] = '{3'd0, 3'd0, 3'd0, 3'd0, 3'd1, 3'd1, 3'd2, 3'd3, 3'd4, 3'd4, 3'd0, 3'd1, 3'd2};
    bit [2:0] erd  [13] = '{3'd4, 3'd4, 3'd4, 3'd4, 3'd4, 3'd0, 3'd0, 3'd0, 3'd0, 3'd3, 3'd3, 3'd3, 3'd3};
    bit [1:0] edr  [13] = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd1, 2'd2, 2'd2, 2'd2, 2'd3, 2'd3};
    bit [1:0] erp  [13] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3, 2'd3, 2'd3, 2'd3, 2'd3, 2'd3, 2'd3, 2'd3, 2'd3};
    for (int i = 0; i < 13; i++) begin
      fire(vi_t[i], !vi_t[i], 1'b0, 1'b1);
      n_vec++;
      if (wr_bank5 !== ewr[i] || rd_bank5 !== erd[i] || wr_switch5 !== vi_t[i] ||
          rd_switch5 !== !vi_t[i] || drop5 !== edr[i] || rep5 !== erp[i]) begin
        n_err++;
        $display("FAIL wrap_sat step %0d: wr=%0d rd=%0d wsw=%b rsw=%b drop=%0d rep=%0d, want wr=%0d rd=%0d drop=%0d rep=%0d",
                 i, wr_bank5, rd_bank5, wr_switch5, rd_switch5, drop5, rep5, ewr[i], erd[i], edr[i], erp[i]);
      end
      settle();
    end
  endtask

  task automatic test_reset_midframe();
    @(negedge clk);
    vin = 1'b1;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    n_vec++;
    if (wr_bank !== 2'd0 || rd_bank !== 2'd3 || wr_switch !== 1'b0 || rd_switch !== 1'b0 ||
        drop_cnt !== 16'd0 || rep_cnt !== 16'd0) begin
      n_err++;
      $display("FAIL midframe_reset: wr=%0d rd=%0d wsw=%b rsw=%b drop=%0d rep=%0d, want 0 3 0 0 0 0",
               wr_bank, rd_bank, wr_switch, rd_switch, drop_cnt, rep_cnt);
    end
    rst = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_vec++;
    if (wr_bank !== 2'd1 || wr_switch !== 1'b1 || rd_bank !== 2'd3) begin
      n_err++;
      $display("FAIL midframe_first: wr=%0d wsw=%b rd=%0d, want 1 1 3", wr_bank, wr_switch, rd_bank);
    end
    settle();
  endtask

  initial begin
    test_reset();
    test_first_frame();
    test_normal_flow();
    test_writer_faster();
    test_reader_faster();
    test_simultaneous();
    test_freeze();
    test_wrap_saturate();
    test_reset_midframe();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
